// File: rtl/loader_pkg.sv
// ----------------------------------------------------------------------------
// loader_pkg
//   Shared definitions for the instruction-memory loader:
//     - loader_state_e : FSM state encoding for instr_loader
//     - MSB_FIRST      : byte order of each word inside a frame
//     - COUNT_MIN      : smallest legal word count in the COUNT byte
//     - bytes_per_word : stream symbols per instruction word
// ----------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } loader_state_e;

    // The first byte of a word on the stream is its most-significant byte.
    localparam bit MSB_FIRST = 1'b1;

    // A frame must carry at least one word.
    localparam int COUNT_MIN = 1;

    function automatic int bytes_per_word(input int instr_width, input int byte_width);
        return instr_width / byte_width;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// ----------------------------------------------------------------------------
// word_assembler
//   Packs stream bytes into one instruction word.
//   Ports:
//     clk, rst     : clock, asynchronous active-low reset
//     clear        : synchronous clear of word register and byte counter
//     shift_en     : accept in_byte this cycle
//     in_byte      : incoming stream symbol
//     word         : word register (complete after the last byte is shifted)
//     last_byte    : the byte being offered now completes the word
// ----------------------------------------------------------------------------
module word_assembler
    import loader_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int BYTE_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   shift_en,
    input  logic [BYTE_WIDTH-1:0]  in_byte,
    output logic [INSTR_WIDTH-1:0] word,
    output logic                   last_byte
);

    localparam int BPW   = bytes_per_word(INSTR_WIDTH, BYTE_WIDTH);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BPW - 1);

    logic [CNT_W-1:0]       byte_cnt;
    logic [INSTR_WIDTH-1:0] byte_ext;
    logic [INSTR_WIDTH-1:0] word_next;

    assign byte_ext  = INSTR_WIDTH'(in_byte);
    assign last_byte = (byte_cnt == LAST_IDX);

    // NOTE: both branches assign word_next, so no latch is inferred.
    always_comb begin
        if (MSB_FIRST) begin
            word_next = (word << BYTE_WIDTH) | byte_ext;
        end else begin
            word_next = (word >> BYTE_WIDTH) | (byte_ext << (INSTR_WIDTH - BYTE_WIDTH));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            word     <= word_next;
            byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// ----------------------------------------------------------------------------
// instr_loader
//   Writer side of the core's instruction memory. Receives a framed byte
//   stream (COUNT, N words MSB-first, CHECK = XOR of data bytes), writes each
//   assembled word to the memory write port and keeps the core in reset
//   until a complete, checksum-verified program is stored.
//   Ports:
//     clk, rst          : clock, asynchronous active-low reset
//     i_start           : begin a load (honoured in IDLE, DONE, ERROR)
//     i_byte, i_valid   : stream symbol and its valid
//     o_ready           : loader accepts i_byte this cycle
//     o_write_enable    : instruction memory write strobe
//     o_write_select    : instruction memory address
//     o_write_data      : instruction word
//     o_cpu_hold        : drives core reset while high
//     o_done, o_error   : frame verified / frame rejected
//     o_words_loaded    : words written in the current frame
// ----------------------------------------------------------------------------
module instr_loader
    import loader_pkg::*;
#(
    parameter int INSTR_WIDTH  = 32,
    parameter int NUM_INSTR    = 11,
    parameter int BYTE_WIDTH   = 8,
    localparam int INSTR_SELECT = $clog2(NUM_INSTR)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [BYTE_WIDTH-1:0]   i_byte,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic                    o_write_enable,
    output logic [INSTR_SELECT-1:0] o_write_select,
    output logic [INSTR_WIDTH-1:0]  o_write_data,
    output logic                    o_cpu_hold,
    output logic                    o_done,
    output logic                    o_error,
    output logic [INSTR_SELECT:0]   o_words_loaded
);

    localparam int WC_W = INSTR_SELECT + 1;
    localparam logic [BYTE_WIDTH-1:0] COUNT_MIN_B = BYTE_WIDTH'(COUNT_MIN);
    localparam logic [BYTE_WIDTH-1:0] COUNT_MAX_B = BYTE_WIDTH'(NUM_INSTR);

    loader_state_e          state;
    logic [WC_W-1:0]        word_cnt;
    logic [WC_W-1:0]        word_cnt_inc;
    logic [WC_W-1:0]        n_words;
    logic [BYTE_WIDTH-1:0]  checksum;
    logic                   xfer;
    logic                   start_ok;
    logic                   asm_clear;
    logic                   asm_shift;
    logic                   last_byte;
    logic [INSTR_WIDTH-1:0] asm_word;

    assign xfer         = i_valid && o_ready;
    assign start_ok     = i_start && (state == IDLE || state == DONE || state == ERROR);
    assign asm_shift    = xfer && (state == DATA);
    // The byte counter restarts for every word; WRITE is the hand-off point.
    assign asm_clear    = start_ok || (state == WRITE);
    assign word_cnt_inc = word_cnt + 1'b1;

    word_assembler #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .BYTE_WIDTH  (BYTE_WIDTH)
    ) u_word_assembler (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .shift_en  (asm_shift),
        .in_byte   (i_byte),
        .word      (asm_word),
        .last_byte (last_byte)
    );

    // The word counter doubles as write address and progress count; the
    // assembled word is stable for the whole WRITE cycle.
    assign o_write_select = word_cnt[INSTR_SELECT-1:0];
    assign o_write_data   = asm_word;
    assign o_words_loaded = word_cnt;

    // Outputs are registered alongside the state so they change on the same
    // edge that enters the state they belong to. o_cpu_hold drops only on
    // the edge into DONE, after the last word has already been written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            o_ready        <= 1'b0;
            o_write_enable <= 1'b0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
            o_cpu_hold     <= 1'b1;
            word_cnt       <= '0;
            n_words        <= '0;
            checksum       <= '0;
        end else begin
            o_write_enable <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (i_start) begin
                        state      <= COUNT;
                        o_ready    <= 1'b1;
                        o_done     <= 1'b0;
                        o_error    <= 1'b0;
                        o_cpu_hold <= 1'b1;
                        word_cnt   <= '0;
                        n_words    <= '0;
                        checksum   <= '0;
                    end
                end
                COUNT: begin
                    if (xfer) begin
                        if (i_byte < COUNT_MIN_B || i_byte > COUNT_MAX_B) begin
                            state   <= ERROR;
                            o_ready <= 1'b0;
                            o_error <= 1'b1;
                        end else begin
                            n_words <= WC_W'(i_byte);
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        checksum <= checksum ^ i_byte;
                        if (last_byte) begin
                            state          <= WRITE;
                            o_ready        <= 1'b0;
                            o_write_enable <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt_inc;
                    o_ready  <= 1'b1;
                    state    <= (word_cnt_inc == n_words) ? CHECK : DATA;
                end
                CHECK: begin
                    if (xfer) begin
                        o_ready <= 1'b0;
                        if (i_byte == checksum) begin
                            state      <= DONE;
                            o_done     <= 1'b1;
                            o_cpu_hold <= 1'b0;
                        end else begin
                            state   <= ERROR;
                            o_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
